// File: rtl/sync_pkt_retry_fifo.sv
// Packet FIFO with write commit/abort and read ack/retry for retransmission.
// Latency: committed data is visible to the reader on the next cycle; oData, counts and afull are registered.
// Backpressure: writes are dropped while full (sets ovf); reads are dropped while empty (sets udf).
module sync_pkt_retry_fifo #(
    parameter int DSIZE    = 8,
    parameter int ASIZE    = 9,
    parameter int AFULL_TH = 448
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             write,
    input  logic [DSIZE-1:0] iData,
    input  logic             wr_commit,
    input  logic             wr_abort,
    input  logic             read,
    input  logic             rd_ack,
    input  logic             rd_retry,
    output logic [DSIZE-1:0] oData,
    output logic [ASIZE:0]   rdnum,
    output logic [ASIZE:0]   freenum,
    output logic             full,
    output logic             empty,
    output logic             afull,
    output logic             ovf,
    output logic             udf
);

    localparam int             DEPTH   = 1 << ASIZE;
    localparam logic [ASIZE:0] DEPTH_V = (ASIZE+1)'(DEPTH);
    localparam logic [ASIZE:0] AFULL_V = (ASIZE+1)'(AFULL_TH);
    localparam logic [ASIZE:0] ONE     = (ASIZE+1)'(1);

    // Packet storage; deliberately not reset.
    logic [DSIZE-1:0] mem_q [DEPTH];

    // Pointers carry one extra wrap bit above the RAM index.
    logic [ASIZE:0] wp_q, wp_d;
    logic [ASIZE:0] wp_cmt_q, wp_cmt_d;
    logic [ASIZE:0] rp_q, rp_d;
    logic [ASIZE:0] rp_ack_q, rp_ack_d;

    logic [DSIZE-1:0] odata_q;
    logic [ASIZE:0]   rdnum_q, rdnum_d;
    logic [ASIZE:0]   freenum_q, freenum_d;
    logic             afull_q, afull_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    logic           full_w;
    logic           empty_w;
    logic           wr_acc;
    logic           rd_acc;
    logic           rewind;
    logic [ASIZE:0] used_w;

    // Full covers everything not yet acked, so retransmittable data is never overwritten.
    assign full_w  = (wp_q[ASIZE] != rp_ack_q[ASIZE]) &&
                     (wp_q[ASIZE-1:0] == rp_ack_q[ASIZE-1:0]);
    assign empty_w = (rp_q == wp_cmt_q);
    assign used_w  = wp_q - rp_ack_q;

    // An ack in the same cycle wins over a retry, so the read then proceeds normally.
    assign rewind  = rd_retry && !rd_ack;
    assign wr_acc  = write && !full_w && !wr_abort;
    assign rd_acc  = read && !empty_w && !rewind;

    // Next-state for the four pointers and the registered status outputs.
    always_comb begin
        wp_d      = wp_q;
        wp_cmt_d  = wp_cmt_q;
        rp_d      = rp_q;
        rp_ack_d  = rp_ack_q;
        rdnum_d   = wp_cmt_q - rp_q;
        freenum_d = DEPTH_V - used_w;
        afull_d   = (used_w >= AFULL_V);
        ovf_d     = ovf_q || (write && full_w);
        udf_d     = udf_q || (read && empty_w && !rd_retry);

        if (wr_abort) begin
            wp_d = wp_cmt_q;
        end else begin
            if (wr_acc) begin
                wp_d = wp_q + ONE;
            end
            if (wr_commit) begin
                wp_cmt_d = wr_acc ? (wp_q + ONE) : wp_q;
            end
        end

        if (rewind) begin
            rp_d = rp_ack_q;
        end else if (rd_acc) begin
            rp_d = rp_q + ONE;
        end

        if (rd_ack) begin
            rp_ack_d = rd_acc ? (rp_q + ONE) : rp_q;
        end
    end

    // Pointer registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wp_q     <= '0;
            wp_cmt_q <= '0;
            rp_q     <= '0;
            rp_ack_q <= '0;
        end else begin
            wp_q     <= wp_d;
            wp_cmt_q <= wp_cmt_d;
            rp_q     <= rp_d;
            rp_ack_q <= rp_ack_d;
        end
    end

    // RAM write port.
    always_ff @(posedge CLK) begin
        if (wr_acc) begin
            mem_q[wp_q[ASIZE-1:0]] <= iData;
        end
    end

    // Registered read data, counts and flags; sticky errors clear only on reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            odata_q   <= '0;
            rdnum_q   <= '0;
            freenum_q <= DEPTH_V;
            afull_q   <= 1'b0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            odata_q   <= mem_q[rp_q[ASIZE-1:0]];
            rdnum_q   <= rdnum_d;
            freenum_q <= freenum_d;
            afull_q   <= afull_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
        end
    end

    assign oData   = odata_q;
    assign rdnum   = rdnum_q;
    assign freenum = freenum_q;
    assign full    = full_w;
    assign empty   = empty_w;
    assign afull   = afull_q;
    assign ovf     = ovf_q;
    assign udf     = udf_q;

endmodule

// File: tb/tb_sync_pkt_retry_fifo.sv
module tb_sync_pkt_retry_fifo;

    localparam int DSIZE = 8;
    localparam int ASIZE = 3;
    localparam int AFTH  = 6;

    logic             CLK = 1'b0;
    logic             RST;
    logic             write, wr_commit, wr_abort, read, rd_ack, rd_retry;
    logic [DSIZE-1:0] iData;
    logic [DSIZE-1:0] oData;
    logic [ASIZE:0]   rdnum, freenum;
    logic             full, empty, afull, ovf, udf;

    int checks   = 0;
    int failures = 0;

    sync_pkt_retry_fifo #(.DSIZE(DSIZE), .ASIZE(ASIZE), .AFULL_TH(AFTH)) dut (
        .CLK(CLK), .RST(RST), .write(write), .iData(iData),
        .wr_commit(wr_commit), .wr_abort(wr_abort), .read(read),
        .rd_ack(rd_ack), .rd_retry(rd_retry), .oData(oData),
        .rdnum(rdnum), .freenum(freenum), .full(full), .empty(empty),
        .afull(afull), .ovf(ovf), .udf(udf)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic push(input logic [7:0] d, input logic cmt);
        write = 1'b1; iData = d; wr_commit = cmt;
        tick();
        write = 1'b0; wr_commit = 1'b0;
    endtask

    // One read, then an idle cycle so oData shows the next word.
    task automatic pop();
        read = 1'b1;
        tick();
        read = 1'b0;
        tick();
    endtask

    task automatic ack();
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        RST = 1'b1;
        #12;
        checks++; if (oData !== 8'h00) begin failures++; $display("FAIL reset_odata got=%h exp=00", oData); end
        checks++; if (rdnum !== 4'd0) begin failures++; $display("FAIL reset_rdnum got=%0d exp=0", rdnum); end
        checks++; if (freenum !== 4'd8) begin failures++; $display("FAIL reset_freenum got=%0d exp=8", freenum); end
        checks++; if ({empty, full, afull, ovf, udf} !== 5'b10000) begin failures++; $display("FAIL reset_flags got=%b exp=10000", {empty, full, afull, ovf, udf}); end
        @(negedge CLK);
        RST = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        for (int i = 0; i < 5; i++) push(8'h10 + 8'(i), i == 4);
        tick();
        checks++; if (rdnum !== 4'd5) begin failures++; $display("FAIL basic_rdnum got=%0d exp=5", rdnum); end
        checks++; if (freenum !== 4'd3) begin failures++; $display("FAIL basic_freenum got=%0d exp=3", freenum); end
        checks++; if (empty !== 1'b0) begin failures++; $display("FAIL basic_notempty got=%b exp=0", empty); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (oData !== 8'h10 + 8'(i)) begin failures++; $display("FAIL basic_data%0d got=%h exp=%h", i, oData, 8'h10 + 8'(i)); end
            pop();
        end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL basic_empty got=%b exp=1", empty); end
        ack();
        checks++; if (freenum !== 4'd8) begin failures++; $display("FAIL basic_free_after_ack got=%0d exp=8", freenum); end
    endtask

    task automatic test_abort();
        for (int i = 0; i < 3; i++) push(8'hA0 + 8'(i), 1'b0);
        wr_abort = 1'b1; write = 1'b1; wr_commit = 1'b1; iData = 8'hAF;
        tick();
        wr_abort = 1'b0; write = 1'b0; wr_commit = 1'b0;
        tick();
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL abort_empty got=%b exp=1", empty); end
        checks++; if (rdnum !== 4'd0) begin failures++; $display("FAIL abort_rdnum got=%0d exp=0", rdnum); end
        checks++; if (freenum !== 4'd8) begin failures++; $display("FAIL abort_freenum got=%0d exp=8", freenum); end
        push(8'h30, 1'b0);
        push(8'h31, 1'b1);
        tick();
        checks++; if (rdnum !== 4'd2) begin failures++; $display("FAIL abort_next_rdnum got=%0d exp=2", rdnum); end
        for (int i = 0; i < 2; i++) begin
            checks++; if (oData !== 8'h30 + 8'(i)) begin failures++; $display("FAIL abort_next_data%0d got=%h exp=%h", i, oData, 8'h30 + 8'(i)); end
            pop();
        end
        ack();
    endtask

    task automatic test_retry();
        for (int i = 0; i < 4; i++) push(8'h40 + 8'(i), i == 3);
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++; if (oData !== 8'h40 + 8'(i)) begin failures++; $display("FAIL retry_first%0d got=%h exp=%h", i, oData, 8'h40 + 8'(i)); end
            pop();
        end
        checks++; if (rdnum !== 4'd0) begin failures++; $display("FAIL retry_drained got=%0d exp=0", rdnum); end
        rd_retry = 1'b1; read = 1'b1;
        tick();
        rd_retry = 1'b0; read = 1'b0;
        tick();
        checks++; if (rdnum !== 4'd4) begin failures++; $display("FAIL retry_rdnum got=%0d exp=4", rdnum); end
        checks++; if (udf !== 1'b0) begin failures++; $display("FAIL retry_no_udf got=%b exp=0", udf); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (oData !== 8'h40 + 8'(i)) begin failures++; $display("FAIL retry_again%0d got=%h exp=%h", i, oData, 8'h40 + 8'(i)); end
            pop();
        end
        checks++; if (freenum !== 4'd4) begin failures++; $display("FAIL retry_free_pre_ack got=%0d exp=4", freenum); end
        ack();
        checks++; if (freenum !== 4'd8) begin failures++; $display("FAIL retry_free_post_ack got=%0d exp=8", freenum); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 8; i++) push(8'h50 + 8'(i), i == 7);
        checks++; if (full !== 1'b1) begin failures++; $display("FAIL full_set got=%b exp=1", full); end
        push(8'hEE, 1'b0);
        tick();
        checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL full_ovf got=%b exp=1", ovf); end
        checks++; if (freenum !== 4'd0) begin failures++; $display("FAIL full_freenum got=%0d exp=0", freenum); end
        checks++; if (afull !== 1'b1) begin failures++; $display("FAIL full_afull got=%b exp=1", afull); end
        checks++; if (rdnum !== 4'd8) begin failures++; $display("FAIL full_rdnum got=%0d exp=8", rdnum); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (oData !== 8'h50 + 8'(i)) begin failures++; $display("FAIL full_data%0d got=%h exp=%h", i, oData, 8'h50 + 8'(i)); end
            pop();
        end
        ack();
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL full_clear got=%b exp=0", full); end
        checks++; if (freenum !== 4'd8) begin failures++; $display("FAIL full_free_after_ack got=%0d exp=8", freenum); end
        checks++; if (afull !== 1'b0) begin failures++; $display("FAIL full_afull_clear got=%b exp=0", afull); end
        read = 1'b1;
        tick();
        read = 1'b0;
        tick();
        checks++; if (udf !== 1'b1) begin failures++; $display("FAIL udf_set got=%b exp=1", udf); end
        checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", ovf); end
    endtask

    task automatic test_random();
        logic [7:0] q[$];
        logic [7:0] val = 8'h80;
        int committed = 0;
        int iter = 0;
        while (committed < 24 && iter < 200) begin
            int len = $urandom_range(1, 4);
            bit drop = ($urandom_range(0, 3) == 0);
            iter++;
            q.delete();
            for (int i = 0; i < len; i++) begin
                push(val, !drop && (i == len - 1));
                if (!drop) q.push_back(val);
                val++;
            end
            if (drop) begin
                wr_abort = 1'b1;
                tick();
                wr_abort = 1'b0;
            end else begin
                committed += len;
            end
            tick();
            checks++; if (rdnum !== 4'(q.size())) begin failures++; $display("FAIL rand_rdnum it%0d got=%0d exp=%0d", iter, rdnum, q.size()); end
            for (int i = 0; i < q.size(); i++) begin
                checks++; if (oData !== q[i]) begin failures++; $display("FAIL rand_data it%0d i%0d got=%h exp=%h", iter, i, oData, q[i]); end
                pop();
            end
            if (q.size() != 0 && $urandom_range(0, 1) == 1) begin
                rd_retry = 1'b1;
                tick();
                rd_retry = 1'b0;
                tick();
                for (int i = 0; i < q.size(); i++) begin
                    checks++; if (oData !== q[i]) begin failures++; $display("FAIL rand_retry it%0d i%0d got=%h exp=%h", iter, i, oData, q[i]); end
                    pop();
                end
            end
            ack();
            checks++; if (freenum !== 4'd8 || empty !== 1'b1) begin failures++; $display("FAIL rand_drain it%0d free=%0d empty=%b exp=8,1", iter, freenum, empty); end
        end
        checks++; if (committed < 24) begin failures++; $display("FAIL rand_budget committed=%0d exp>=24", committed); end
    endtask

    task automatic test_midreset();
        push(8'h60, 1'b0);
        push(8'h61, 1'b1);
        push(8'h62, 1'b0);
        tick();
        checks++; if (rdnum !== 4'd2) begin failures++; $display("FAIL mid_pre_rdnum got=%0d exp=2", rdnum); end
        RST = 1'b1;
        #1;
        checks++; if ({empty, full, afull, ovf, udf} !== 5'b10000) begin failures++; $display("FAIL mid_flags got=%b exp=10000", {empty, full, afull, ovf, udf}); end
        checks++; if (rdnum !== 4'd0 || freenum !== 4'd8 || oData !== 8'h00) begin failures++; $display("FAIL mid_counts rdnum=%0d free=%0d odata=%h exp=0,8,00", rdnum, freenum, oData); end
        @(negedge CLK);
        RST = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) push(8'h70 + 8'(i), i == 2);
        tick();
        checks++; if (rdnum !== 4'd3) begin failures++; $display("FAIL mid_post_rdnum got=%0d exp=3", rdnum); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (oData !== 8'h70 + 8'(i)) begin failures++; $display("FAIL mid_post_data%0d got=%h exp=%h", i, oData, 8'h70 + 8'(i)); end
            pop();
        end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL mid_post_empty got=%b exp=1", empty); end
    endtask

    initial begin
        RST = 1'b1;
        write = 1'b0; wr_commit = 1'b0; wr_abort = 1'b0;
        read = 1'b0; rd_ack = 1'b0; rd_retry = 1'b0;
        iData = '0;
        test_reset();
        test_basic();
        test_abort();
        test_retry();
        test_full();
        test_random();
        test_midreset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sync_pkt_retry_fifo.md
SYNC_PKT_RETRY_FIFO -- requirements
Module: sync_pkt_retry_fifo

Interface
REQ-001 Parameter DSIZE, default 8, data width in bits.
REQ-002 Parameter ASIZE, default 9, address width; depth = 2**ASIZE entries.
REQ-003 Parameter AFULL_TH, default 448, almost-full threshold on occupied entries.
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 RST  input  1  asynchronous, active-high reset.
REQ-006 write  input  1  push iData at wp when not full.
REQ-007 iData  input  DSIZE  write data.
REQ-008 wr_commit  input  1  make all written data up to and including this cycle's write readable.
REQ-009 wr_abort  input  1  discard uncommitted written data.
REQ-010 read  input  1  advance rp when not empty.
REQ-011 rd_ack  input  1  release all data read so far; space becomes writable.
REQ-012 rd_retry  input  1  rewind rp to last acked point, for packet retransmit.
REQ-013 oData  output  DSIZE  registered read data.
REQ-014 rdnum  output  ASIZE+1  registered count of committed, unread entries.
REQ-015 freenum  output  ASIZE+1  registered count of writable entries.
REQ-016 full, empty, afull  output  1 each  status flags.
REQ-017 ovf, udf  output  1 each  sticky error flags.

Function
REQ-018 Four ASIZE+1-bit pointers SHALL be kept: wp, wp_cmt, rp, rp_ack; extra MSB is wrap bit; RAM is indexed with the low ASIZE bits.
REQ-019 Invariant: rp_ack <= rp <= wp_cmt <= wp, modulo 2**(ASIZE+1).
REQ-020 full SHALL be combinational: wrap bits of wp and rp_ack differ and low bits equal.
REQ-021 empty SHALL be combinational: rp == wp_cmt.
REQ-022 write & ~full & ~wr_abort: RAM[wp] <= iData, wp <= wp+1.
REQ-023 wr_abort SHALL take priority: wp <= wp_cmt; write and wr_commit in the same cycle are ignored.
REQ-024 wr_commit without abort: wp_cmt <= wp+1 if an accepted write occurs that cycle, else wp.
REQ-025 rd_retry without rd_ack: rp <= rp_ack; read that cycle is ignored.
REQ-026 rd_ack: rp_ack <= rp+1 if an accepted read occurs that cycle, else rp; rp advances normally; rd_retry that cycle is ignored.
REQ-027 read & ~empty, no retry: rp <= rp+1.
REQ-028 oData SHALL update every cycle with RAM[rp low bits]: one-cycle latency from an rp change, first-word-fall-through semantics.
REQ-029 rdnum <= wp_cmt - rp; freenum <= 2**ASIZE - (wp - rp_ack); both registered, ASIZE+1-bit modular arithmetic, sampled from pre-edge pointers.
REQ-030 afull SHALL be registered: high when (wp - rp_ack) >= AFULL_TH.
REQ-031 ovf SHALL set on write & full; udf SHALL set on read & empty & ~rd_retry; both remain set until reset.
REQ-032 Pointer wrap past 2**(ASIZE+1) SHALL be seamless; no count or flag glitch at wrap.
REQ-033 Depth 2**ASIZE SHALL be fully usable: full when exactly 2**ASIZE entries are unacked.

Reset
REQ-034 RST high: all pointers 0, oData 0, rdnum 0, freenum 2**ASIZE, afull/ovf/udf 0; empty=1, full=0 immediately.
REQ-035 RAM contents SHALL NOT be reset.
REQ-036 Reset mid-packet SHALL discard all committed and uncommitted data; no partial state survives.

Verification
REQ-037 Write 5 bytes 0x10..0x14, commit on last -> rdnum=5 two cycles later; read 5 -> oData 0x10..0x14 in order; empty=1.
REQ-038 Write 3, wr_abort -> wp=wp_cmt, rdnum unchanged, empty stays 1; next committed packet reads back without aborted bytes.
REQ-039 Commit 4 bytes, read 4, rd_retry -> rp=rp_ack, rdnum=4, re-read yields the same 4 bytes; rd_ack after them -> freenum rises by 4.
REQ-040 ASIZE=3: write 8 unacked -> full=1, 9th write sets ovf, data intact; ack all -> full=0, freenum=8.
REQ-041 Run 3*2**ASIZE bytes through with random commit/abort/ack/retry against a scoreboard -> no data mismatch, invariants hold across wrap.
REQ-042 Assert RST during a half-written packet -> all outputs at reset values same cycle; post-reset packet read correctly.
